packet_snooper: RTL

PACKET_SNOOPER -- requirements
Module: packet_snooper

---
 rtl/packet_snooper_pkg.sv | 15 +
 rtl/packet_snooper_counter.sv | 20 ++
 rtl/packet_snooper.sv | 124 ++++++++++++
 3 files changed

// File: rtl/packet_snooper_pkg.sv
// Shared types and defaults for the packet snooper: state encoding,
// default datapath widths and statistics counter width.
package packet_snooper_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
  localparam int unsigned COUNT_WIDTH        = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DROP = 2'd2
  } snoop_state_e;

endpackage

// File: rtl/packet_snooper_counter.sv
// Free-running statistics counter: increments on enable, wraps modulo
// 2^COUNT_WIDTH, asynchronously cleared by rst_n.
module snoop_counter
  import packet_snooper_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/packet_snooper.sv
// Passive AXI-Stream tap that copies whole packets into a packet memory
// when downstream is ready, otherwise drops them, and keeps statistics.
module packet_snooper
  import packet_snooper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tap_tdata,
  input  logic                  tap_tvalid,
  input  logic                  tap_tready,
  input  logic                  tap_tlast,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  done,
  input  logic                  mem_ready,
  output logic                  truncated,
  output logic [31:0]           pkt_count,
  output logic [31:0]           drop_count
);

  snoop_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  wr_en_d, done_d, trunc_d, drop_inc;
  logic                  beat, at_last_addr;

  assign beat         = tap_tvalid && tap_tready;
  assign at_last_addr = (wr_addr == '1);

  // wr_addr doubles as the packet write pointer: in COPY it always holds the
  // last written address, so reaching all-ones means the memory is full.
  always_comb begin
    state_d  = state_q;
    addr_d   = wr_addr;
    data_d   = wr_data;
    wr_en_d  = 1'b0;
    done_d   = 1'b0;
    trunc_d  = 1'b0;
    drop_inc = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (beat) begin
          // mem_ready lags done by a cycle, so a start during done is refused
          if (mem_ready && !done) begin
            wr_en_d = 1'b1;
            addr_d  = '0;
            data_d  = tap_tdata;
            if (tap_tlast) begin
              done_d = 1'b1;
            end else begin
              state_d = COPY;
            end
          end else begin
            drop_inc = 1'b1;
            if (!tap_tlast) begin
              state_d = DROP;
            end
          end
        end
      end

      COPY: begin
        if (beat) begin
          if (!at_last_addr) begin
            wr_en_d = 1'b1;
            addr_d  = wr_addr + ADDR_WIDTH'(1);
            data_d  = tap_tdata;
          end
          if (tap_tlast) begin
            done_d  = 1'b1;
            trunc_d = at_last_addr;
            state_d = IDLE;
          end
        end
      end

      DROP: begin
        if (beat && tap_tlast) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      done      <= 1'b0;
      truncated <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr   <= addr_d;
      wr_data   <= data_d;
      wr_en     <= wr_en_d;
      done      <= done_d;
      truncated <= trunc_d;
    end
  end

  snoop_counter u_pkt_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done_d),
    .count (pkt_count)
  );

  snoop_counter u_drop_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .count (drop_count)
  );

endmodule
